// File: rtl/fifo_21_pkg.sv
// rtl/fifo_21_pkg.sv - shared constants and word layout for the ADC-to-dispatch FIFO
package fifo_21_pkg;

  localparam int FIFO21_W_SRC  = 5;
  localparam int FIFO21_W_DATA = 18;
  localparam int FIFO21_WIDTH  = FIFO21_W_SRC + FIFO21_W_DATA;
  localparam int FIFO21_DEPTH  = 16;

  typedef struct packed {
    logic [FIFO21_W_SRC-1:0]  src;
    logic [FIFO21_W_DATA-1:0] data;
  } fifo21_word_t;

endpackage

// File: rtl/sync_fifo_21_if.sv
// rtl/sync_fifo_21_if.sv - push/pop handshake bundle between producer/consumer and the FIFO
interface sync_fifo_21_if
  import fifo_21_pkg::*;
#(
  parameter int WIDTH = FIFO21_WIDTH
);

  logic [WIDTH-1:0] din;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] dout;
  logic             valid;
  logic             full;

  modport master (
    output din, wr_en, rd_en,
    input  dout, valid, full
  );

  modport slave (
    input  din, wr_en, rd_en,
    output dout, valid, full
  );

endinterface

// File: rtl/fifo_21_ram.sv
// rtl/fifo_21_ram.sv - simple dual-port storage, synchronous write, asynchronous read
module fifo_21_ram #(
  parameter int WIDTH = 23,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // contents are deliberately not reset; occupancy tracking makes stale words invisible
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_21.sv
// rtl/sync_fifo_21.sv - FWFT single-clock FIFO; SYNC_FIFO_21_COUNT_EN exposes data_count
module sync_fifo_21
  import fifo_21_pkg::*;
#(
  parameter int WIDTH = FIFO21_WIDTH,
  parameter int DEPTH = FIFO21_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  sync_fifo_21_if.slave      fifo
`ifdef SYNC_FIFO_21_COUNT_EN
  ,
  output logic [AW:0]        data_count
`endif
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;
  logic [WIDTH-1:0] rdata;

  // a pop frees a slot on the same edge, so a full FIFO still accepts a write alongside a read
  assign do_pop  = fifo.rd_en & (count != '0);
  assign do_push = fifo.wr_en & ((count != FULL_CNT) | do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  fifo_21_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (do_push),
    .waddr (wr_ptr),
    .wdata (fifo.din),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  assign fifo.valid = (count != '0);
  assign fifo.full  = (count == FULL_CNT);
  assign fifo.dout  = fifo.valid ? rdata : '0;

`ifdef SYNC_FIFO_21_COUNT_EN
  assign data_count = count;
`endif

endmodule

// File: tb/tb_sync_fifo_21.sv
// tb/tb_sync_fifo_21.sv - scoreboard bench for sync_fifo_21 with a queue reference model
module tb_sync_fifo_21;
  import fifo_21_pkg::*;

  localparam int W = FIFO21_WIDTH;
  localparam int D = FIFO21_DEPTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_21_if #(.WIDTH(W)) bus ();

`ifdef SYNC_FIFO_21_COUNT_EN
  logic [$clog2(D):0] dc;
`endif

  sync_fifo_21 #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk        (clk),
    .rst        (rst_n),
    .fifo       (bus)
`ifdef SYNC_FIFO_21_COUNT_EN
    ,
    .data_count (dc)
`endif
  );

  // reference model: the words currently held, oldest first
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: inputs are stable at the falling edge, so outputs and the pending read are judged here
  always @(negedge clk) begin
    chk("valid", 32'(bus.valid), 32'(exp_q.size() != 0));
    chk("full", 32'(bus.full), 32'(exp_q.size() == D));
    if (exp_q.size() == 0) chk("dout_empty", 32'(bus.dout), 32'h0);
    else                   chk("dout_head", 32'(bus.dout), 32'(exp_q[0]));
`ifdef SYNC_FIFO_21_COUNT_EN
    chk("data_count", 32'(dc), 32'(exp_q.size()));
`endif
    if (rst_n && bus.rd_en && exp_q.size() != 0) void'(exp_q.pop_front());
  end

  // one clock of stimulus, entered and left at posedge+1
  task automatic cyc(input logic wr, input logic [W-1:0] d, input logic rd);
    bit acc;
    bus.wr_en = wr;
    bus.din   = d;
    bus.rd_en = rd;
    acc = wr && ((exp_q.size() < D) || (rd && exp_q.size() != 0));
    @(negedge clk);
    #1;
    if (acc) exp_q.push_back(d);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rand_word();
    fifo21_word_t w;
    w.src  = FIFO21_W_SRC'($urandom);
    w.data = FIFO21_W_DATA'($urandom);
    return w;
  endfunction

  initial begin
    bus.din   = '0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 32'(bus.valid), 32'h0);
    chk("reset_full", 32'(bus.full), 32'h0);
    chk("reset_dout", 32'(bus.dout), 32'h0);
    rst_n = 1'b1;

    // first push right after release, then drain
    cyc(1'b1, W'('h1ABCD), 1'b0);
    chk("first_push_dout", 32'(bus.dout), 32'h1ABCD);
    cyc(1'b0, '0, 1'b1);

    // fill, overflow drop, drain in order
    for (int i = 0; i < D; i++) cyc(1'b1, W'(i), 1'b0);
    chk("full_after_fill", 32'(bus.full), 32'h1);
    cyc(1'b1, W'('h7FFFFF), 1'b0);
    for (int i = 0; i < D; i++) cyc(1'b0, '0, 1'b1);
    chk("empty_after_drain", 32'(bus.valid), 32'h0);

    // simultaneous read/write while full
    for (int i = 0; i < D; i++) cyc(1'b1, W'(i + 'h100), 1'b0);
    cyc(1'b1, W'('h55), 1'b1);
    chk("full_held", 32'(bus.full), 32'h1);
    for (int i = 0; i < D; i++) cyc(1'b0, '0, 1'b1);

    // count==1 replace, then read-and-write into empty
    cyc(1'b1, W'('hA), 1'b0);
    cyc(1'b1, W'('hB), 1'b1);
    chk("replace_dout", 32'(bus.dout), 32'hB);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b1, W'('hC), 1'b1);
    chk("rw_empty_dout", 32'(bus.dout), 32'hC);
    cyc(1'b0, '0, 1'b1);

    // underflow reads are ignored
    repeat (3) cyc(1'b0, '0, 1'b1);

    // asynchronous reset with five words held
    for (int i = 0; i < 5; i++) cyc(1'b1, rand_word(), 1'b0);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_valid", 32'(bus.valid), 32'h0);
    chk("midrst_dout", 32'(bus.dout), 32'h0);
`ifdef SYNC_FIFO_21_COUNT_EN
    chk("midrst_count", 32'(dc), 32'h0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // wrap-around with occupancy kept in 0..3
    for (int i = 0; i < 40; i++) begin
      logic wr;
      wr = (exp_q.size() < 3) ? 1'($urandom) : 1'b0;
      cyc(wr, rand_word(), 1'($urandom));
    end

    // unconstrained random traffic, write-biased then read-biased
    for (int i = 0; i < 150; i++) cyc(($urandom % 4) != 0, rand_word(), ($urandom % 3) == 0);
    for (int i = 0; i < 150; i++) cyc(($urandom % 3) == 0, rand_word(), ($urandom % 4) != 0);

    while (exp_q.size() != 0) cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
